// File: rtl/seq_barrel_shifter_pkg.sv
// Shared types for the sequential barrel shifter.
// Mode and FSM state encodings plus a counter-width helper.
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    MODE_ROL     = 3'b000,
    MODE_ROR     = 3'b001,
    MODE_SLL     = 3'b010,
    MODE_SRL     = 3'b011,
    MODE_SRA     = 3'b100,
    MODE_REV_ROL = 3'b101,
    MODE_RSV6    = 3'b110,
    MODE_RSV7    = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Stage counter holds 0..w-1; keep at least one bit.
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_barrel_shifter_shift_stage.sv
// One barrel stage: moves data by 2**k when enabled.
// Mode 101 rotates left only when SEQ_SHIFTER_REVERSE_EN is defined.
module shift_stage
  import seq_shifter_pkg::*;
#(
  parameter int width = 3,
  parameter int k     = 0
) (
  input  mode_t                mode,
  input  logic                 en,
  input  logic [2**width-1:0]  data,
  output logic [2**width-1:0]  result
);

  localparam int N = 2**width;
  localparam int D = 2**k;

  logic [N-1:0] rol;
  logic [N-1:0] ror;
  logic [N-1:0] sll;
  logic [N-1:0] srl;
  logic [N-1:0] sra;

  assign rol = (data << D) | (data >> (N - D));
  assign ror = (data >> D) | (data << (N - D));
  assign sll = data << D;
  assign srl = data >> D;
  assign sra = $unsigned($signed(data) >>> D);

  always_comb begin
    result = data;
    if (en) begin
      case (mode)
        MODE_ROL: result = rol;
        MODE_ROR: result = ror;
        MODE_SLL: result = sll;
        MODE_SRL: result = srl;
        MODE_SRA: result = sra;
`ifdef SEQ_SHIFTER_REVERSE_EN
        MODE_REV_ROL: result = rol;
`endif
        default:  result = data;
      endcase
    end
  end

endmodule

// File: rtl/seq_barrel_shifter.sv
// Sequential barrel shifter: one stage per cycle, fixed latency.
// Optional bit-reverse-then-rotate mode via SEQ_SHIFTER_REVERSE_EN.
module seq_barrel_shifter
  import seq_shifter_pkg::*;
#(
  parameter int width = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          mode,
  input  logic [width-1:0]    shift_amt,
  input  logic [2**width-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2**width-1:0] data_out
);

  localparam int N  = 2**width;
  localparam int CW = cnt_bits(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_t            state;
  state_t            state_nxt;
  mode_t             mode_q;
  logic [width-1:0]  amt_q;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      work;
  logic [N-1:0]      work_nxt;
  logic [N-1:0]      load;
  logic [N-1:0]      stage_res [width];
  logic              accept;
  logic              last;

`ifdef SEQ_SHIFTER_REVERSE_EN
  logic [N-1:0] rev;

  for (genvar i = 0; i < N; i++) begin : g_rev
    assign rev[i] = data_in[N-1-i];
  end

  assign load = (mode == MODE_REV_ROL) ? rev : data_in;
`else
  assign load = data_in;
`endif

  for (genvar s = 0; s < width; s++) begin : g_stage
    shift_stage #(
      .width (width),
      .k     (s)
    ) u_stage (
      .mode   (mode_q),
      .en     (amt_q[s]),
      .data   (work),
      .result (stage_res[s])
    );
  end

  // Only the stage matching the counter may update the working register.
  always_comb begin
    work_nxt = work;
    for (int s = 0; s < width; s++) begin
      if (cnt == CW'(s)) work_nxt = stage_res[s];
    end
  end

  assign last   = (cnt == LAST);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (in_valid)  state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)      state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_ROL;
      amt_q  <= '0;
      cnt    <= '0;
      work   <= '0;
    end else if (accept) begin
      mode_q <= mode_t'(mode);
      amt_q  <= shift_amt;
      cnt    <= '0;
      work   <= load;
    end else if (state == ST_SHIFT) begin
      work   <= work_nxt;
      cnt    <= last ? '0 : cnt + CW'(1);
    end
  end

  assign data_out = work;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Directed bench for seq_barrel_shifter at width=2 (4-bit data).
// Honours SEQ_SHIFTER_REVERSE_EN for the mode 101 expectation.
module tb_seq_barrel_shifter;

  localparam int W = 2;
  localparam int N = 4;

`ifdef SEQ_SHIFTER_REVERSE_EN
  localparam logic [N-1:0] REV_EXP = 4'b0110;
`else
  localparam logic [N-1:0] REV_EXP = 4'b1100;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   mode;
  logic [W-1:0] shift_amt;
  logic [N-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] data_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_barrel_shifter #(
    .width (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .shift_amt (shift_amt),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  task automatic chk(input string tag,
                     input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept, check exact 2-cycle latency and result, then drain.
  task automatic run(input string tag,
                     input logic [2:0] m,
                     input logic [W-1:0] a,
                     input logic [N-1:0] d,
                     input logic [N-1:0] exp);
    in_valid  = 1'b1;
    mode      = m;
    shift_amt = a;
    data_in   = d;
    chk1({tag, ".in_ready"}, in_ready, 1'b1);
    tick;
    in_valid  = 1'b0;
    mode      = ~m;
    shift_amt = ~a;
    data_in   = ~d;
    chk1({tag, ".ov_c0"}, out_valid, 1'b0);
    tick;
    chk1({tag, ".ov_c1"}, out_valid, 1'b0);
    tick;
    chk1({tag, ".ov_c2"}, out_valid, 1'b1);
    chk({tag, ".data"}, data_out, exp);
    chk1({tag, ".busy"}, in_ready, 1'b0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk1({tag, ".drain_ov"}, out_valid, 1'b0);
    chk1({tag, ".drain_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 3'b000;
    shift_amt = '0;
    data_in   = '0;
    tick;
    tick;
    chk1("rst.in_ready", in_ready, 1'b1);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk("rst.data_out", data_out, 4'b0000);

    // Request offered while reset is high must not be taken.
    in_valid = 1'b1;
    data_in  = 4'b1111;
    tick;
    reset    = 1'b0;
    in_valid = 1'b0;
    chk1("rst_req.in_ready", in_ready, 1'b1);
    tick;
    tick;
    tick;
    chk1("rst_req.out_valid", out_valid, 1'b0);
    chk("rst_req.data_out", data_out, 4'b0000);

    run("rol1", 3'b000, 2'b01, 4'b1100, 4'b1001);
    run("ror1", 3'b001, 2'b01, 4'b1100, 4'b0110);
    run("sra2", 3'b100, 2'b10, 4'b1001, 4'b1110);
    run("sll3", 3'b010, 2'b11, 4'b1001, 4'b1000);
    run("srl0", 3'b011, 2'b00, 4'b1001, 4'b1001);
    run("rol3", 3'b000, 2'b11, 4'b0001, 4'b1000);
    run("ror3", 3'b001, 2'b11, 4'b0001, 4'b0010);
    run("srl2", 3'b011, 2'b10, 4'b1100, 4'b0011);
    run("sra1", 3'b100, 2'b01, 4'b0110, 4'b0011);
    run("rev1", 3'b101, 2'b01, 4'b1100, REV_EXP);
    run("rsv7", 3'b111, 2'b11, 4'b0110, 4'b0110);

    // Backpressure with noisy inputs during SHIFT and DONE.
    in_valid  = 1'b1;
    mode      = 3'b100;
    shift_amt = 2'b10;
    data_in   = 4'b1001;
    tick;
    mode      = 3'b000;
    shift_amt = 2'b01;
    data_in   = 4'b0101;
    tick;
    tick;
    chk1("bp.ov_rise", out_valid, 1'b1);
    chk("bp.data_rise", data_out, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      data_in = 4'(i);
      tick;
      chk1("bp.hold_ov", out_valid, 1'b1);
      chk("bp.hold_data", data_out, 4'b1110);
      chk1("bp.hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick;
    chk1("bp.release_rdy", in_ready, 1'b1);
    chk1("bp.release_ov", out_valid, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick;
    chk1("bp.idle_rdy", in_ready, 1'b1);

    // Abort one cycle after acceptance.
    in_valid  = 1'b1;
    mode      = 3'b000;
    shift_amt = 2'b01;
    data_in   = 4'b1100;
    tick;
    in_valid  = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    chk1("abort.out_valid", out_valid, 1'b0);
    chk("abort.data_out", data_out, 4'b0000);
    chk1("abort.in_ready", in_ready, 1'b1);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk1("abort.no_stale", out_valid, 1'b0);
    end
    chk("abort.data_after", data_out, 4'b0000);

    run("post_abort", 3'b010, 2'b01, 4'b0011, 4'b0110);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
